regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 64x32 register file between N writeback sources: ALU, load unit, and branch-and-link.
- Keeps a 64-bit busy scoreboard of registers with outstanding writes, so decode can stall on read-after-write (RAW) and write-after-write (WAW) hazards.
- Sits between the execute/memory units and the register file write port. Decode drives the reservation and hazard-query ports.

---
 rtl/regfile_wb_arbiter_if.sv | 17 +
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the execute/memory units and the
// register-file writeback arbiter.
// master: a writeback source (drives valid/addr/data, sees the grant).
// slave:  the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int N      = 3,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [N-1:0]        req_valid;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_ready;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a busy scoreboard.
// Round-robin arbitration of N writeback sources onto the single write port,
// one pipeline register in front of the register file, and a per-register
// busy bit that decode uses for RAW/WAW stalls.
// Optional macro REGFILE_WB_BYPASS_EN adds rs1_fwd/rs2_fwd/fwd_data so a
// consumer can take the in-flight write data instead of stalling one cycle.
module regfile_wb_arbiter #(
  parameter int N      = 3,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  localparam int GW    = (N > 1) ? $clog2(N) : 1,
  localparam int NREG  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave wb,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [GW-1:0]     last_grant
);

  // Unpacked views of the packed request buses.
  logic [ADDR_W-1:0] addr_a [N];
  logic [DATA_W-1:0] data_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign addr_a[gi] = wb.req_addr[gi*ADDR_W +: ADDR_W];
    assign data_a[gi] = wb.req_data[gi*DATA_W +: DATA_W];
  end

  logic              rf_wr_en_q,   rf_wr_en_d;
  logic [ADDR_W-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [NREG-1:0]   busy_q,       busy_d;

  logic [N-1:0]      grant;
  logic [GW-1:0]     grant_idx;
  logic              found;
  logic [GW-1:0]     cand;
  logic              xfer;
  logic              rsv_hit;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = last_grant_q;
    for (int k = 0; k < N; k++) begin
      cand = (cand == GW'(N-1)) ? '0 : cand + GW'(1);
      if (!found && wb.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found && !rst) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign wb.req_ready = grant;
  assign xfer         = |grant;

  // A reservation is accepted when the register is idle, or when its
  // outstanding write is retiring this very cycle (keeps WAW ordering).
  assign rsv_hit   = rf_wr_en_q && (rf_wr_addr_q == rsv_addr);
  assign rsv_ready = ~busy_q[rsv_addr] | rsv_hit;

  // Next-state for the write pipeline register, grant pointer and scoreboard.
  always_comb begin
    rf_wr_en_d   = xfer;
    rf_wr_addr_d = xfer ? addr_a[grant_idx] : rf_wr_addr_q;
    rf_wr_data_d = xfer ? data_a[grant_idx] : rf_wr_data_q;
    last_grant_d = xfer ? grant_idx : last_grant_q;
    busy_d       = busy_q;
    // Clear first so a same-edge reservation of the same register wins.
    if (rf_wr_en_q) begin
      busy_d[rf_wr_addr_q] = 1'b0;
    end
    if (rsv_valid && rsv_ready) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // State registers; reset drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      last_grant_q <= GW'(N-1);
      busy_q       <= '0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign last_grant = last_grant_q;

`ifdef REGFILE_WB_BYPASS_EN
  // The retiring write is forwarded, so the source is not reported busy.
  logic rs1_hit, rs2_hit;
  assign rs1_hit  = rf_wr_en_q && (rf_wr_addr_q == rs1_addr);
  assign rs2_hit  = rf_wr_en_q && (rf_wr_addr_q == rs2_addr);
  assign rs1_fwd  = rs1_hit;
  assign rs2_fwd  = rs2_hit;
  assign fwd_data = rf_wr_data_q;
  assign rs1_busy = busy_q[rs1_addr] & ~rs1_hit;
  assign rs2_busy = busy_q[rs2_addr] & ~rs2_hit;
`else
  // Busy stays set through the writing cycle; the register file read
  // reflects the write only on the following cycle.
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: an abstract model (grant pointer, busy
// set, pending write) checked against the DUT every cycle, plus directed
// literal checks for each scenario.
module tb_regfile_wb_arbiter;
  localparam int N      = 3;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int GW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rsv_valid = 1'b0;
  logic [ADDR_W-1:0] rsv_addr = '0;
  logic              rsv_ready;
  logic [ADDR_W-1:0] rs1_addr = '0;
  logic [ADDR_W-1:0] rs2_addr = '0;
  logic              rs1_busy, rs2_busy;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [GW-1:0]     last_grant;
`ifdef REGFILE_WB_BYPASS_EN
  logic              rs1_fwd, rs2_fwd;
  logic [DATA_W-1:0] fwd_data;
`endif

  regfile_wb_arbiter_if #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb_if ();

  regfile_wb_arbiter #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb_if),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rsv_ready  (rsv_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_fwd    (rs1_fwd),
    .rs2_fwd    (rs2_fwd),
    .fwd_data   (fwd_data),
`endif
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_live = 1'b0;
  int                m_lg;
  logic [63:0]       m_busy;
  bit                m_wen;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;

  // First valid requester after lg, wrapping; -1 when none.
  function automatic int mgrant(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  function automatic logic m_rsv_ok(input logic [ADDR_W-1:0] a);
    return !m_busy[a] || (m_wen && m_waddr == a);
  endfunction

  function automatic logic [63:0] next_busy(input logic [63:0] b, input bit wen,
      input logic [ADDR_W-1:0] wa, input logic ok, input logic [ADDR_W-1:0] ra);
    logic [63:0] r;
    r = b;
    if (wen) r[wa] = 1'b0;
    if (ok) r[ra] = 1'b1;
    return r;
  endfunction

  // Model state advance at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_live  <= 1'b1;
      m_lg    <= N - 1;
      m_busy  <= '0;
      m_wen   <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
    end else if (m_live) begin
      m_busy <= next_busy(m_busy, m_wen, m_waddr, rsv_valid && m_rsv_ok(rsv_addr), rsv_addr);
      if (mgrant(wb_if.req_valid, m_lg) >= 0) begin
        m_wen   <= 1'b1;
        m_waddr <= wb_if.req_addr[mgrant(wb_if.req_valid, m_lg)*ADDR_W +: ADDR_W];
        m_wdata <= wb_if.req_data[mgrant(wb_if.req_valid, m_lg)*DATA_W +: DATA_W];
        m_lg    <= mgrant(wb_if.req_valid, m_lg);
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  // Compare every DUT output against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_live) begin
      logic [N-1:0] exp_rdy;
      logic         h1, h2;
      int           g;
      g       = mgrant(wb_if.req_valid, m_lg);
      exp_rdy = '0;
      if (!rst && g >= 0) exp_rdy = N'(1) << g;
      h1 = m_wen && m_waddr == rs1_addr;
      h2 = m_wen && m_waddr == rs2_addr;
      chk("req_ready", 64'(wb_if.req_ready), 64'(exp_rdy));
      chk("rsv_ready", 64'(rsv_ready), 64'(m_rsv_ok(rsv_addr)));
      chk("rf_wr_en", 64'(rf_wr_en), 64'(m_wen));
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(m_waddr));
      chk("rf_wr_data", 64'(rf_wr_data), 64'(m_wdata));
      chk("last_grant", 64'(last_grant), 64'(m_lg));
`ifdef REGFILE_WB_BYPASS_EN
      chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr] && !h1));
      chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr] && !h2));
      chk("rs1_fwd", 64'(rs1_fwd), 64'(h1));
      chk("rs2_fwd", 64'(rs2_fwd), 64'(h2));
      chk("fwd_data", 64'(fwd_data), 64'(m_wdata));
`else
      chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_addr]));
      chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_addr]));
`endif
      if (rf_wr_en === 1'b1)
        $display("[TB] writeback r%0d <= %08h (last_grant %0d)", rf_wr_addr, rf_wr_data, last_grant);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_if.req_addr[i*ADDR_W +: ADDR_W] = a;
    wb_if.req_data[i*DATA_W +: DATA_W] = d;
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic WRITING_BUSY = 1'b0;
`else
  localparam logic WRITING_BUSY = 1'b1;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    wb_if.req_valid = '0;
    wb_if.req_addr  = '0;
    wb_if.req_data  = '0;
    rst = 1'b1;
    tick();
    tick();

    // 1: round-robin from reset, three back-to-back writes
    rst = 1'b0;
    wb_if.req_valid = 3'b111;
    set_req(0, 6'd1, 32'hA);
    set_req(1, 6'd2, 32'hB);
    set_req(2, 6'd3, 32'hC);
    @(negedge clk);
    chk("t1 reset en", 64'(rf_wr_en), 64'd0);
    chk("t1 reset lg", 64'(last_grant), 64'd2);
    chk("t1 ready0", 64'(wb_if.req_ready), 64'b001);
    tick();
    @(negedge clk);
    chk("t1 ready1", 64'(wb_if.req_ready), 64'b010);
    chk("t1 wr1 en", 64'(rf_wr_en), 64'd1);
    chk("t1 wr1 addr", 64'(rf_wr_addr), 64'd1);
    chk("t1 wr1 data", 64'(rf_wr_data), 64'hA);
    tick();
    @(negedge clk);
    chk("t1 ready2", 64'(wb_if.req_ready), 64'b100);
    chk("t1 wr2 addr", 64'(rf_wr_addr), 64'd2);
    chk("t1 wr2 data", 64'(rf_wr_data), 64'hB);
    tick();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("t1 wr3 en", 64'(rf_wr_en), 64'd1);
    chk("t1 wr3 addr", 64'(rf_wr_addr), 64'd3);
    chk("t1 wr3 data", 64'(rf_wr_data), 64'hC);
    chk("t1 lg", 64'(last_grant), 64'd2);
    tick();
    @(negedge clk);
    chk("t1 idle en", 64'(rf_wr_en), 64'd0);
    chk("t1 hold addr", 64'(rf_wr_addr), 64'd3);

    // 2: reserve r5, RAW busy until its write retires
    tick();
    rsv_valid = 1'b1;
    rsv_addr  = 6'd5;
    @(negedge clk);
    chk("t2 rsv_ready", 64'(rsv_ready), 64'd1);
    tick();
    rsv_valid = 1'b0;
    rs1_addr  = 6'd5;
    @(negedge clk);
    chk("t2 busy a", 64'(rs1_busy), 64'd1);
    tick();
    wb_if.req_valid = 3'b010;
    set_req(1, 6'd5, 32'h55);
    @(negedge clk);
    chk("t2 busy b", 64'(rs1_busy), 64'd1);
    chk("t2 ready", 64'(wb_if.req_ready), 64'b010);
    tick();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("t2 wr addr", 64'(rf_wr_addr), 64'd5);
    chk("t2 busy writing", 64'(rs1_busy), 64'(WRITING_BUSY));
    tick();
    @(negedge clk);
    chk("t2 busy cleared", 64'(rs1_busy), 64'd0);

    // 3: WAW - second reservation waits for the retiring write
    tick();
    rsv_valid = 1'b1;
    rsv_addr  = 6'd5;
    @(negedge clk);
    chk("t3 rsv first", 64'(rsv_ready), 64'd1);
    tick();
    @(negedge clk);
    chk("t3 rsv second", 64'(rsv_ready), 64'd0);
    tick();
    wb_if.req_valid = 3'b010;
    set_req(1, 6'd5, 32'h66);
    @(negedge clk);
    chk("t3 rsv pre-write", 64'(rsv_ready), 64'd0);
    tick();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("t3 wr en", 64'(rf_wr_en), 64'd1);
    chk("t3 rsv writing", 64'(rsv_ready), 64'd1);
    tick();
    rsv_valid = 1'b0;
    @(negedge clk);
    chk("t3 set wins", 64'(rs1_busy), 64'd1);
    chk("t3 rsv after", 64'(rsv_ready), 64'd0);
    tick();
    wb_if.req_valid = 3'b001;
    set_req(0, 6'd5, 32'h77);
    tick();
    wb_if.req_valid = '0;
    tick();
    @(negedge clk);
    chk("t3 cleanup", 64'(rs1_busy), 64'd0);

    // 4: unreserved write to r31 leaves the scoreboard empty
    tick();
    wb_if.req_valid = 3'b100;
    set_req(2, 6'd31, 32'h1234);
    @(negedge clk);
    chk("t4 ready", 64'(wb_if.req_ready), 64'b100);
    tick();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("t4 wr en", 64'(rf_wr_en), 64'd1);
    chk("t4 wr addr", 64'(rf_wr_addr), 64'd31);
    chk("t4 wr data", 64'(rf_wr_data), 64'h1234);
    for (int i = 0; i < 64; i++) begin
      tick();
      rs1_addr = 6'(i);
      rs2_addr = 6'(63 - i);
      @(negedge clk);
      chk("t4 sweep rs1", 64'(rs1_busy), 64'd0);
      chk("t4 sweep rs2", 64'(rs2_busy), 64'd0);
    end

    // 5: reset drops an in-flight write and clears busy
    tick();
    rsv_valid = 1'b1;
    rsv_addr  = 6'd7;
    tick();
    rsv_valid = 1'b0;
    rs1_addr  = 6'd7;
    @(negedge clk);
    chk("t5 busy7", 64'(rs1_busy), 64'd1);
    tick();
    rst = 1'b1;
    wb_if.req_valid = 3'b001;
    set_req(0, 6'd2, 32'h88);
    @(negedge clk);
    chk("t5 ready in rst", 64'(wb_if.req_ready), 64'd0);
    tick();
    rst = 1'b0;
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("t5 en", 64'(rf_wr_en), 64'd0);
    chk("t5 lg", 64'(last_grant), 64'd2);
    chk("t5 addr", 64'(rf_wr_addr), 64'd0);
    chk("t5 data", 64'(rf_wr_data), 64'd0);
    chk("t5 busy7 cleared", 64'(rs1_busy), 64'd0);

    // 6: writing cycle of a reserved register (forwarded or stalled)
    tick();
    rsv_valid = 1'b1;
    rsv_addr  = 6'd9;
    tick();
    rsv_valid = 1'b0;
    rs2_addr  = 6'd9;
    wb_if.req_valid = 3'b001;
    set_req(0, 6'd9, 32'hDEAD);
    @(negedge clk);
    chk("t6 ready", 64'(wb_if.req_ready), 64'b001);
    chk("t6 busy pre", 64'(rs2_busy), 64'd1);
    tick();
    wb_if.req_valid = '0;
    @(negedge clk);
    chk("t6 wr data", 64'(rf_wr_data), 64'hDEAD);
    chk("t6 busy writing", 64'(rs2_busy), 64'(WRITING_BUSY));
`ifdef REGFILE_WB_BYPASS_EN
    chk("t6 fwd", 64'(rs2_fwd), 64'd1);
    chk("t6 fwd_data", 64'(fwd_data), 64'hDEAD);
`endif
    tick();
    @(negedge clk);
    chk("t6 busy after", 64'(rs2_busy), 64'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
